// File: rtl/bsg_dmc_pkg.sv
// Shared types and helpers for the DMC clock/reset sequencer.
//   bsg_dmc_clk_seq_state_e : sequencer FSM state, also exported on state_o.
//   slot_len()              : cycles spent per delay-line group slot.
package bsg_dmc_pkg;

    localparam int unsigned StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        StIdle    = 3'd0,
        StHold    = 3'd1,
        StProg    = 3'd2,
        StRelease = 3'd3,
        StRun     = 3'd4,
        StUpdate  = 3'd5
    } bsg_dmc_clk_seq_state_e;

    // One load cycle followed by the settle window.
    function automatic int unsigned slot_len(input int unsigned settle_cycles);
        return settle_cycles + 1;
    endfunction

endpackage

// File: rtl/bsg_dmc_clk_div_en.sv
// Programmable-ratio clock enable generator.
//   clk_i, async_reset_n_i : clock and asynchronous active-low reset
//   en_i                   : count enable; when low the count is held at 0
//   clear_i                : restart the period and reload the ratio from div_i
//   div_i                  : period minus 1, sampled at each wrap
//   clk_en_o               : registered enable, high once per period
module bsg_dmc_clk_div_en #(
    parameter int unsigned div_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   async_reset_n_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic [div_width_p-1:0] div_i,
    output logic                   clk_en_o
);

    logic [div_width_p-1:0] cnt_q, cnt_d;
    logic [div_width_p-1:0] div_q, div_d;
    logic                   clk_en_q, clk_en_d;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        clk_en_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (en_i) begin
            if (cnt_q == div_q) begin
                // Ratio changes only land on a period boundary.
                clk_en_d = 1'b1;
                cnt_d    = '0;
                div_d    = div_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            cnt_q    <= '0;
            div_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule

// File: rtl/bsg_dmc_clk_rst_seq.sv
// DMC clock/reset sequencer: holds the controller in reset, programs each DQS
// delay line in turn (load, trigger, settle), releases reset, then serves
// runtime delay-code updates through a valid/ready handshake.
//   clk_i, async_reset_n_i : 2x clock, asynchronous active-low reset
//   en_i                   : level enable, low returns to IDLE
//   div_i                  : 1x enable period minus 1
//   dly_code_i             : requested codes, group g at [g*W +: W]
//   dly_update_v_i/ready_o : runtime reprogram handshake
//   dly_code_o, dly_trigger_o : registered codes and per-group load pulses
//   sync_reset_o, clk_en_1x_o, ready_o, state_o : controller reset, 1x enable,
//                            RUN indicator, debug state
module bsg_dmc_clk_rst_seq
    import bsg_dmc_pkg::*;
#(
    parameter int unsigned dq_group_p          = 4,
    parameter int unsigned dly_code_width_p    = 6,
    parameter int unsigned reset_hold_cycles_p = 16,
    parameter int unsigned settle_cycles_p     = 8,
    parameter int unsigned div_width_p         = 4
) (
    input  logic                                   clk_i,
    input  logic                                   async_reset_n_i,
    input  logic                                   en_i,
    input  logic [div_width_p-1:0]                 div_i,
    input  logic [dq_group_p*dly_code_width_p-1:0] dly_code_i,
    input  logic                                   dly_update_v_i,
    output logic                                   dly_update_ready_o,
    output logic [dq_group_p*dly_code_width_p-1:0] dly_code_o,
    output logic [dq_group_p-1:0]                  dly_trigger_o,
    output logic                                   sync_reset_o,
    output logic                                   clk_en_1x_o,
    output logic                                   ready_o,
    output logic [StateWidth-1:0]                  state_o
);

    localparam int unsigned CodeW   = dq_group_p * dly_code_width_p;
    localparam int unsigned SlotLen = slot_len(settle_cycles_p);
    localparam int unsigned CntMax  = (reset_hold_cycles_p > SlotLen) ? reset_hold_cycles_p
                                                                      : SlotLen;
    localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned GrpW    = (dq_group_p > 1) ? $clog2(dq_group_p) : 1;

    bsg_dmc_clk_seq_state_e state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [GrpW-1:0]        group_q, group_d;
    logic [CodeW-1:0]       shadow_q, shadow_d;
    logic [CodeW-1:0]       code_q, code_d;
    logic [dq_group_p-1:0]  trig_q, trig_d;
    logic                   sync_reset_q, sync_reset_d;
    logic                   ready_q, ready_d;
    logic                   upd_ready_q, upd_ready_d;

    logic accept, slot_last, grp_last, in_slot, div_cnt_en, div_clear;

    always_comb begin
        // Handshake is judged on the registered ready the requester sees.
        accept    = en_i && (state_q == StRun) && upd_ready_q && dly_update_v_i;
        slot_last = (cnt_q == CntW'(SlotLen - 1));
        grp_last  = (group_q == GrpW'(dq_group_p - 1));
        in_slot   = (state_q == StProg) || (state_q == StUpdate);

        state_d  = state_q;
        cnt_d    = cnt_q;
        group_d  = group_q;
        shadow_d = shadow_q;
        code_d   = code_q;
        trig_d   = '0;

        if (!en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            group_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHold;
                    cnt_d   = '0;
                    group_d = '0;
                end
                StHold: begin
                    if (cnt_q == CntW'(reset_hold_cycles_p - 1)) begin
                        state_d  = StProg;
                        cnt_d    = '0;
                        group_d  = '0;
                        shadow_d = dly_code_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StProg, StUpdate: begin
                    if (slot_last) begin
                        cnt_d = '0;
                        if (grp_last) begin
                            state_d = (state_q == StProg) ? StRelease : StRun;
                            group_d = '0;
                        end else begin
                            group_d = group_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRelease: state_d = StRun;
                StRun: begin
                    if (accept) begin
                        state_d  = StUpdate;
                        cnt_d    = '0;
                        group_d  = '0;
                        shadow_d = dly_code_i;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Slot cycle 0 loads the code, slot cycle 1 pulses that group's trigger.
        if (en_i && in_slot) begin
            if (cnt_q == '0) begin
                code_d[group_q*dly_code_width_p +: dly_code_width_p] =
                    shadow_q[group_q*dly_code_width_p +: dly_code_width_p];
            end
            if (cnt_q == CntW'(1)) begin
                trig_d[group_q] = 1'b1;
            end
        end

        sync_reset_d = !(en_i && ((state_q == StRelease) || (state_q == StRun) ||
                                  (state_q == StUpdate)));
        ready_d      = en_i && (state_q == StRun) && !accept;
        upd_ready_d  = ready_d;

        div_cnt_en = en_i && ((state_q == StRelease) || (state_q == StRun) ||
                              (state_q == StUpdate));
        div_clear  = en_i && (state_q == StRelease);
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            group_q      <= '0;
            shadow_q     <= '0;
            code_q       <= '0;
            trig_q       <= '0;
            sync_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            upd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            group_q      <= group_d;
            shadow_q     <= shadow_d;
            code_q       <= code_d;
            trig_q       <= trig_d;
            sync_reset_q <= sync_reset_d;
            ready_q      <= ready_d;
            upd_ready_q  <= upd_ready_d;
        end
    end

    bsg_dmc_clk_div_en #(
        .div_width_p(div_width_p)
    ) u_div (
        .clk_i          (clk_i),
        .async_reset_n_i(async_reset_n_i),
        .en_i           (div_cnt_en),
        .clear_i        (div_clear),
        .div_i          (div_i),
        .clk_en_o       (clk_en_1x_o)
    );

    assign dly_update_ready_o = upd_ready_q;
    assign dly_code_o         = code_q;
    assign dly_trigger_o      = trig_q;
    assign sync_reset_o       = sync_reset_q;
    assign ready_o            = ready_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_bsg_dmc_clk_rst_seq.sv
// Directed bench for bsg_dmc_clk_rst_seq with default parameters.
module tb_bsg_dmc_clk_rst_seq;

    logic        clk_i = 1'b0;
    logic        async_reset_n_i;
    logic        en_i;
    logic [3:0]  div_i;
    logic [23:0] dly_code_i;
    logic        dly_update_v_i;
    logic        dly_update_ready_o;
    logic [23:0] dly_code_o;
    logic [3:0]  dly_trigger_o;
    logic        sync_reset_o;
    logic        clk_en_1x_o;
    logic        ready_o;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int trig_cnt = 0;
    int multi_hot = 0;

    typedef struct {
        int          e;
        logic [2:0]  st;
        logic        srst;
        logic        rdy;
        logic [3:0]  trig;
        logic        cke;
        logic [23:0] code;
    } vec_t;

    vec_t tbl [16];

    bsg_dmc_clk_rst_seq dut (
        .clk_i             (clk_i),
        .async_reset_n_i   (async_reset_n_i),
        .en_i              (en_i),
        .div_i             (div_i),
        .dly_code_i        (dly_code_i),
        .dly_update_v_i    (dly_update_v_i),
        .dly_update_ready_o(dly_update_ready_o),
        .dly_code_o        (dly_code_o),
        .dly_trigger_o     (dly_trigger_o),
        .sync_reset_o      (sync_reset_o),
        .clk_en_1x_o       (clk_en_1x_o),
        .ready_o           (ready_o),
        .state_o           (state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #2;
        if (dly_trigger_o != 4'b0) trig_cnt++;
        if ($countones(dly_trigger_o) > 1) multi_hot++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        edge_n++;
        @(negedge clk_i);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // en_i is already high; returns the edge index at which ready_o first reads high.
    task automatic run_seq(output int lat);
        lat = -1;
        do begin
            tick();
            lat++;
        end while (!ready_o && lat < 200);
    endtask

    task automatic gap(output int g);
        g = 0;
        do begin
            tick();
            g++;
        end while (!clk_en_1x_o && g < 100);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_srst"}, sync_reset_o, 1);
        chk({tag, "_rdy"}, ready_o, 0);
        chk({tag, "_urdy"}, dly_update_ready_o, 0);
        chk({tag, "_trig"}, dly_trigger_o, 0);
        chk({tag, "_cke"}, clk_en_1x_o, 0);
        chk({tag, "_code"}, dly_code_o, 0);
    endtask

    initial begin
        int t0;
        int lat;
        int g;
        int n_upd;
        logic bad;
        logic [23:0] code_a;
        logic [23:0] code_b;
        logic [23:0] code_c;
        logic [3:0]  exp_cke [9];

        code_a = {6'd3, 6'd10, 6'd21, 6'd63};
        code_b = {6'd1, 6'd2, 6'd3, 6'd4};
        code_c = {6'd8, 6'd7, 6'd6, 6'd5};

        //          edge st    srst  rdy   trig     cke   code
        tbl[0]  = '{0,  3'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h0};
        tbl[1]  = '{15, 3'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h0};
        tbl[2]  = '{16, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h0};
        tbl[3]  = '{17, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h00003F};
        tbl[4]  = '{18, 3'd2, 1'b1, 1'b0, 4'b0001, 1'b0, 24'h00003F};
        tbl[5]  = '{19, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h00003F};
        tbl[6]  = '{26, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h00057F};
        tbl[7]  = '{27, 3'd2, 1'b1, 1'b0, 4'b0010, 1'b0, 24'h00057F};
        tbl[8]  = '{35, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h00A57F};
        tbl[9]  = '{36, 3'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 24'h00A57F};
        tbl[10] = '{44, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h0CA57F};
        tbl[11] = '{45, 3'd2, 1'b1, 1'b0, 4'b1000, 1'b0, 24'h0CA57F};
        tbl[12] = '{52, 3'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 24'h0CA57F};
        tbl[13] = '{53, 3'd4, 1'b0, 1'b0, 4'b0000, 1'b0, 24'h0CA57F};
        tbl[14] = '{54, 3'd4, 1'b0, 1'b1, 4'b0000, 1'b1, 24'h0CA57F};
        tbl[15] = '{55, 3'd4, 1'b0, 1'b1, 4'b0000, 1'b1, 24'h0CA57F};

        async_reset_n_i = 1'b0;
        en_i            = 1'b0;
        div_i           = 4'd0;
        dly_code_i      = code_a;
        dly_update_v_i  = 1'b0;
        #12;
        chk_reset_outputs("por");
        @(negedge clk_i);
        async_reset_n_i = 1'b1;
        tick();
        tick();
        chk("idle_hold_state", state_o, 0);
        chk("idle_hold_srst", sync_reset_o, 1);

        // Power-up sequence; the request changes mid-PROG and must not leak in.
        en_i   = 1'b1;
        edge_n = -1;
        t0     = trig_cnt;
        for (int i = 0; i < 16; i++) begin
            while (edge_n < tbl[i].e) begin
                tick();
                if (edge_n == 20) dly_code_i = 24'h0;
            end
            chk($sformatf("seq%0d_state", tbl[i].e), state_o, tbl[i].st);
            chk($sformatf("seq%0d_srst", tbl[i].e), sync_reset_o, tbl[i].srst);
            chk($sformatf("seq%0d_rdy", tbl[i].e), ready_o, tbl[i].rdy);
            chk($sformatf("seq%0d_urdy", tbl[i].e), dly_update_ready_o, tbl[i].rdy);
            chk($sformatf("seq%0d_trig", tbl[i].e), dly_trigger_o, tbl[i].trig);
            chk($sformatf("seq%0d_cke", tbl[i].e), clk_en_1x_o, tbl[i].cke);
            chk($sformatf("seq%0d_code", tbl[i].e), dly_code_o, tbl[i].code);
        end
        chk("seq_trigger_count", trig_cnt - t0, 4);

        // div 0: every cycle; switch to 3 lands at the next wrap.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("div0_cke%0d", i), clk_en_1x_o, 1);
        end
        div_i = 4'd3;
        exp_cke = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("div3_cke%0d", i), clk_en_1x_o, exp_cke[i]);
        end
        div_i = 4'd15;
        gap(g);
        chk("div15_first_gap", g, 4);
        gap(g);
        chk("div15_gap", g, 16);
        gap(g);
        chk("div15_gap2", g, 16);
        div_i = 4'd0;

        // Runtime update.
        dly_code_i     = code_b;
        dly_update_v_i = 1'b1;
        tick();
        dly_update_v_i = 1'b0;
        dly_code_i     = 24'h0;
        chk("upd_enter_state", state_o, 5);
        n_upd = 0;
        bad   = 1'b0;
        while (state_o == 3'd5 && n_upd < 100) begin
            if (ready_o || dly_update_ready_o || sync_reset_o) bad = 1'b1;
            n_upd++;
            tick();
        end
        chk("upd_cycles", n_upd, 36);
        chk("upd_ready_low_srst_low", bad, 0);
        chk("upd_back_state", state_o, 4);
        chk("upd_back_rdy_lag", ready_o, 0);
        tick();
        chk("upd_done_rdy", ready_o, 1);
        chk("upd_done_urdy", dly_update_ready_o, 1);
        chk("upd_done_code", dly_code_o, code_b);

        // en_i low beats a simultaneous update request.
        en_i           = 1'b0;
        dly_update_v_i = 1'b1;
        dly_code_i     = code_c;
        tick();
        dly_update_v_i = 1'b0;
        chk("enlow_state", state_o, 0);
        chk("enlow_srst", sync_reset_o, 1);
        chk("enlow_rdy", ready_o, 0);
        chk("enlow_cke", clk_en_1x_o, 0);
        chk("enlow_code_kept", dly_code_o, code_b);
        dly_code_i = code_a;
        en_i       = 1'b1;
        run_seq(lat);
        chk("rerun_latency", lat, 54);
        chk("rerun_code", dly_code_o, code_a);

        // Drop en_i at the start of the group-2 slot.
        en_i = 1'b0;
        tick();
        en_i       = 1'b1;
        dly_code_i = code_c;
        for (int i = 0; i <= 34; i++) tick();
        en_i = 1'b0;
        tick();
        chk("abort_state", state_o, 0);
        chk("abort_srst", sync_reset_o, 1);
        chk("abort_cke", clk_en_1x_o, 0);
        t0 = trig_cnt;
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_trig", trig_cnt - t0, 0);
        chk("abort_code", dly_code_o, {6'd3, 6'd10, 6'd6, 6'd5});
        en_i = 1'b1;
        run_seq(lat);
        chk("abort_rerun_latency", lat, 54);
        chk("abort_rerun_code", dly_code_o, code_c);

        // Asynchronous reset in the middle of an update.
        dly_code_i     = code_b;
        dly_update_v_i = 1'b1;
        tick();
        dly_update_v_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("arst_pre_state", state_o, 5);
        #2;
        async_reset_n_i = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(negedge clk_i);
        async_reset_n_i = 1'b1;
        #1;
        chk("arst_release_state", state_o, 0);
        chk("arst_release_srst", sync_reset_o, 1);
        @(negedge clk_i);
        chk("arst_restart_state", state_o, 1);
        chk("arst_restart_trig", dly_trigger_o, 0);

        chk("trigger_one_hot", multi_hot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_dmc_clk_rst_seq.md
Name: bsg_dmc_clk_rst_seq

Overview:
- Parametrised next-generation clock/reset sequencer for the DRAM controller (DMC).
- Replaces fixed tag-driven reset and a fixed 2x->1x downsample with an on-chip sequence: hold controller reset, program N DQS delay-line codes one group at a time with trigger pulses and settle time, release reset, then run.
- Provides a programmable-ratio 1x clock enable and a valid/ready handshake for runtime delay-code updates without resetting the controller.

Parameters:
- dq_group_p, 4, number of DQS groups / delay lines.
- dly_code_width_p, 6, width of each delay-line code.
- reset_hold_cycles_p, 16, cycles sync_reset_o is held in HOLD (>=1).
- settle_cycles_p, 8, per-group slot length minus 1 (>=2).
- div_width_p, 4, width of divider ratio.

Ports:
- clk_i  in  1  sequencer clock (2x DFI clock domain).
- async_reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  level enable; low forces IDLE.
- div_i  in  div_width_p  1x enable period minus 1.
- dly_code_i  in  dq_group_p*dly_code_width_p  requested codes, group g at [g*W +: W].
- dly_update_v_i  in  1  runtime reprogram request.
- dly_update_ready_o  out  1  request accepted when v&ready.
- dly_code_o  out  dq_group_p*dly_code_width_p  registered codes to delay lines.
- dly_trigger_o  out  dq_group_p  one-cycle per-group load pulse.
- sync_reset_o  out  1  controller reset, active-high.
- clk_en_1x_o  out  1  1x-phase clock enable.
- ready_o  out  1  sequencer in RUN.
- state_o  out  3  debug state encoding.

Behaviour:
- Clock and reset: one clock (clk_i); async_reset_n_i is asynchronous, active-low. Assertion immediately forces all outputs to reset values.
- Reset values: state IDLE, sync_reset_o=1, clk_en_1x_o=0, dly_trigger_o=0, dly_code_o=0, ready_o=0, dly_update_ready_o=0, counters 0.
- All outputs are registered.
- FSM states: IDLE(0), HOLD(1), PROG(2), RELEASE(3), RUN(4), UPDATE(5).
- IDLE:
  - sync_reset_o=1, divider held at 0.
  - en_i=1 sampled -> HOLD.
- HOLD:
  - Lasts exactly reset_hold_cycles_p cycles, then -> PROG.
  - dly_code_i is snapshotted into a shadow register on the HOLD->PROG transition.
- PROG:
  - Groups are processed g=0..dq_group_p-1; each slot is 1+settle_cycles_p cycles.
  - Slot cycle 0: dly_code_o[g] loads shadow[g].
  - Slot cycle 1: dly_trigger_o[g]=1; at most one trigger bit is high in any cycle.
  - After the last slot -> RELEASE.
- RELEASE:
  - One cycle; sync_reset_o=0 from this cycle onward.
  - Divider count cleared to 0.
  - -> RUN.
- RUN:
  - ready_o=1, dly_update_ready_o=1.
  - On v&ready, snapshot dly_code_i -> UPDATE.
- UPDATE:
  - Same slot sequence as PROG; sync_reset_o stays 0.
  - ready_o=0, dly_update_ready_o=0.
  - After the last slot -> RUN.
- Latency: en_i sampled at edge k gives ready_o=1 at edge k+2+H+G*(1+S). Defaults: k+54.
- en_i=0 in any non-IDLE state: next state is IDLE.
  - sync_reset_o=1 and clk_en_1x_o=0 next cycle.
  - Any trigger in flight is suppressed.
  - dly_code_o retains its last value.
- Divider:
  - Counts only in RELEASE/RUN/UPDATE.
  - clk_en_1x_o=1 on cycles where count==div_q, then count wraps to 0.
  - div_q captures div_i at wrap and on RELEASE; mid-period changes take effect at the next wrap.
  - div_i=0 gives an enable every cycle; the all-ones ratio gives a period of 2^div_width_p.
- Simultaneous events:
  - en_i low together with dly_update_v_i in RUN: en_i wins and the request is not accepted.
  - async reset during PROG aborts the sequence; no partial trigger is emitted after deassertion.

Decomposition:
- bsg_dmc_pkg holds:
  - typedef enum bsg_dmc_clk_seq_state_e (3-bit), reused by state_o;
  - localparam slot length helper.
- Sub-module bsg_dmc_clk_div_en holds:
  - counter plus div_q register;
  - ports clk_i, async_reset_n_i, en_i, clear_i, div_i, clk_en_o.
- Top-level owns the FSM, slot/group counters and the shadow register.

Test Plan:
- Reset then en_i=1 at edge 0 with defaults:
  - sync_reset_o falls at edge 53 and ready_o rises at edge 54.
  - dly_trigger_o pulses 0001,0010,0100,1000 at edges 18,27,36,45.
- dly_code_i={6'd3,6'd10,6'd21,6'd63}, changed to all-zero mid-PROG: dly_code_o ends {3,10,21,63}; the snapshot holds.
- In RUN, v=1 with new codes {1,2,3,4}:
  - ready_o low for 36 cycles and sync_reset_o stays 0.
  - Codes update, then ready_o and dly_update_ready_o return high.
- div_i=0 then 3 in RUN:
  - Enable every cycle, then every 4th cycle starting after the next wrap.
  - div_i=15 gives a period of 16.
- en_i dropped during group-2 slot: next cycle state IDLE, sync_reset_o=1, no further triggers; re-enable reruns the full 54-cycle sequence.
- async_reset_n_i pulsed low mid-UPDATE: outputs immediately return to reset values, and state_o=0 after deassertion.
